jtag_dmi_bridge: RTL and testbench

Parametrised successor to the single-width debug transport shim. Implements the RISC-V 0.13 DTM register set (dtmcs, dmi) as serial shift chains driven by clk-synchronous TAP strobes, and issues req/resp transactions to the Debug Module. Adds busy/sticky-error tracking, dmireset/dmihardreset and a configurable address width. Sits between the TAP front-end (BSCAN or soft TAP, already synchronised to clk) and the DM.

---
 rtl/jtag_dmi_bridge_if.sv | 38 +++
 rtl/jtag_dmi_bridge.sv | 188 ++++++++++++++++++
 tb/tb_jtag_dmi_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dmi_bridge_if.sv
// DMI request/response bus between the DTM bridge (master) and the DM (slave).
interface jtag_dmi_bridge_if #(
  parameter int unsigned ABITS = 7
);
  logic             debug_req_valid;
  logic             debug_req_ready;
  logic [ABITS-1:0] debug_req_bits_addr;
  logic [1:0]       debug_req_bits_op;
  logic [31:0]      debug_req_bits_data;
  logic             debug_resp_valid;
  logic             debug_resp_ready;
  logic [1:0]       debug_resp_bits_resp;
  logic [31:0]      debug_resp_bits_data;

  modport master (
    output debug_req_valid,
    input  debug_req_ready,
    output debug_req_bits_addr,
    output debug_req_bits_op,
    output debug_req_bits_data,
    input  debug_resp_valid,
    output debug_resp_ready,
    input  debug_resp_bits_resp,
    input  debug_resp_bits_data
  );

  modport slave (
    input  debug_req_valid,
    output debug_req_ready,
    input  debug_req_bits_addr,
    input  debug_req_bits_op,
    input  debug_req_bits_data,
    output debug_resp_valid,
    input  debug_resp_ready,
    output debug_resp_bits_resp,
    output debug_resp_bits_data
  );
endinterface

// File: rtl/jtag_dmi_bridge.sv
// RISC-V 0.13 DTM: dtmcs/dmi shift chains bridged to DMI req/resp.
// Define DTM_IDCODE_EN to add the tap_sel_idcode port and IDCODE chain.
module jtag_dmi_bridge #(
  parameter int unsigned ABITS      = 7,
  parameter int unsigned IDLE_HINT  = 1,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic clk,
  input  logic reset,
  input  logic tap_sel_dtmcs,
  input  logic tap_sel_dmi,
`ifdef DTM_IDCODE_EN
  input  logic tap_sel_idcode,
`endif
  input  logic tap_capture,
  input  logic tap_shift,
  input  logic tap_update,
  input  logic tap_tdi,
  output logic tap_tdo,
  jtag_dmi_bridge_if.master dmi
);
  localparam int unsigned N = ABITS + 34;
  localparam logic [2:0] LP_IDLE  = 3'(IDLE_HINT);
  localparam logic [5:0] LP_ABITS = 6'(ABITS);

  logic [31:0]      r_dtmcs, w_dtmcs_n;
  logic [N-1:0]     r_dmi, w_dmi_n;
  logic             r_req_valid, w_req_valid_n;
  logic [ABITS-1:0] r_addr, w_addr_n;
  logic [1:0]       r_op, w_op_n;
  logic [31:0]      r_data, w_data_n;
  logic             r_pending, w_pending_n;
  logic             r_discard, w_discard_n;
  logic [1:0]       r_sticky, w_sticky_n;
  logic [31:0]      r_resp_data, w_resp_data_n;
  logic [1:0]       w_opfield;

  logic w_sel_cs, w_sel_dmi;
  logic w_upd, w_cap, w_sh;
  logic w_resp_ready, w_resp_fire;

`ifdef DTM_IDCODE_EN
  logic [31:0] r_idc, w_idc_n;
  logic        w_sel_id;
  assign w_sel_id = tap_sel_idcode & ~tap_sel_dtmcs & ~tap_sel_dmi;
`else
  logic w_unused_idcode;
  assign w_unused_idcode = ^IDCODE_VAL;
`endif

  assign w_sel_cs  = tap_sel_dtmcs;
  assign w_sel_dmi = tap_sel_dmi & ~tap_sel_dtmcs;
  assign w_upd = tap_update;
  assign w_cap = tap_capture & ~tap_update;
  assign w_sh  = tap_shift & ~tap_update & ~tap_capture;

  assign w_resp_ready = r_pending | r_discard;
  assign w_resp_fire  = dmi.debug_resp_valid & w_resp_ready;

  assign dmi.debug_req_valid     = r_req_valid;
  assign dmi.debug_req_bits_addr = r_addr;
  assign dmi.debug_req_bits_op   = r_op;
  assign dmi.debug_req_bits_data = r_data;
  assign dmi.debug_resp_ready    = w_resp_ready;

  always_comb begin
    w_dtmcs_n     = r_dtmcs;
    w_dmi_n       = r_dmi;
    w_req_valid_n = r_req_valid;
    w_addr_n      = r_addr;
    w_op_n        = r_op;
    w_data_n      = r_data;
    w_pending_n   = r_pending;
    w_discard_n   = r_discard;
    w_sticky_n    = r_sticky;
    w_resp_data_n = r_resp_data;
`ifdef DTM_IDCODE_EN
    w_idc_n       = r_idc;
`endif
    if (r_req_valid & dmi.debug_req_ready)
      w_req_valid_n = 1'b0;
    // Response first so a same-cycle update sees its effect.
    if (w_resp_fire) begin
      if (r_discard) begin
        w_discard_n = 1'b0;
      end else begin
        if (r_op == 2'd1)
          w_resp_data_n = dmi.debug_resp_bits_data;
        if (dmi.debug_resp_bits_resp[1])
          w_sticky_n = dmi.debug_resp_bits_resp;
        w_pending_n = 1'b0;
      end
    end
    w_opfield = w_pending_n ? 2'd3 : w_sticky_n;
    unique case (1'b1)
      w_sel_cs: begin
        if (w_upd) begin
          if (r_dtmcs[16] | r_dtmcs[17])
            w_sticky_n = 2'd0;
          if (r_dtmcs[17]) begin
            w_req_valid_n = 1'b0;
            w_discard_n   = w_discard_n | w_pending_n;
            w_pending_n   = 1'b0;
          end
        end else if (w_cap) begin
          w_dtmcs_n = {14'b0, 3'b0, LP_IDLE,
                       w_sticky_n, LP_ABITS, 4'd1};
        end else if (w_sh) begin
          w_dtmcs_n = {tap_tdi, r_dtmcs[31:1]};
        end
      end
      w_sel_dmi: begin
        if (w_upd) begin
          if ((r_dmi[1] ^ r_dmi[0]) && w_sticky_n == 2'd0) begin
            // A request still outstanding makes this one a busy error.
            if (w_pending_n | w_req_valid_n) begin
              w_sticky_n = 2'd3;
            end else begin
              w_addr_n      = r_dmi[N-1:34];
              w_data_n      = r_dmi[33:2];
              w_op_n        = r_dmi[1:0];
              w_req_valid_n = 1'b1;
              w_pending_n   = 1'b1;
            end
          end
        end else if (w_cap) begin
          w_dmi_n = {r_addr, w_resp_data_n, w_opfield};
        end else if (w_sh) begin
          w_dmi_n = {tap_tdi, r_dmi[N-1:1]};
        end
      end
`ifdef DTM_IDCODE_EN
      w_sel_id: begin
        if (w_cap && !w_upd)
          w_idc_n = IDCODE_VAL;
        else if (w_sh)
          w_idc_n = {tap_tdi, r_idc[31:1]};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    tap_tdo = 1'b0;
    unique case (1'b1)
      w_sel_cs:  tap_tdo = r_dtmcs[0];
      w_sel_dmi: tap_tdo = r_dmi[0];
`ifdef DTM_IDCODE_EN
      w_sel_id:  tap_tdo = r_idc[0];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dtmcs     <= '0;
      r_dmi       <= '0;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_op        <= '0;
      r_data      <= '0;
      r_pending   <= 1'b0;
      r_discard   <= 1'b0;
      r_sticky    <= '0;
      r_resp_data <= '0;
    end else begin
      r_dtmcs     <= w_dtmcs_n;
      r_dmi       <= w_dmi_n;
      r_req_valid <= w_req_valid_n;
      r_addr      <= w_addr_n;
      r_op        <= w_op_n;
      r_data      <= w_data_n;
      r_pending   <= w_pending_n;
      r_discard   <= w_discard_n;
      r_sticky    <= w_sticky_n;
      r_resp_data <= w_resp_data_n;
    end
  end

`ifdef DTM_IDCODE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_idc <= '0;
    else       r_idc <= w_idc_n;
  end
`endif
endmodule

// File: tb/tb_jtag_dmi_bridge.sv
// Directed self-checking bench for jtag_dmi_bridge (ABITS=7, IDLE_HINT=1).
module tb_jtag_dmi_bridge;
  logic clk;
  logic reset;
  logic tap_sel_dtmcs, tap_sel_dmi, tap_sel_idcode;
  logic tap_capture, tap_shift, tap_update, tap_tdi;
  logic tap_tdo;
  logic [63:0] dout;
  int n_checks;
  int n_fail;

  jtag_dmi_bridge_if #(.ABITS(7)) dmi ();

  jtag_dmi_bridge #(
    .ABITS(7),
    .IDLE_HINT(1),
    .IDCODE_VAL(32'h2495_11C3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tap_sel_dtmcs(tap_sel_dtmcs),
    .tap_sel_dmi(tap_sel_dmi),
`ifdef DTM_IDCODE_EN
    .tap_sel_idcode(tap_sel_idcode),
`endif
    .tap_capture(tap_capture),
    .tap_shift(tap_shift),
    .tap_update(tap_update),
    .tap_tdi(tap_tdi),
    .tap_tdo(tap_tdo),
    .dmi(dmi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [6:0] a,
                                     input logic [31:0] d,
                                     input logic [1:0] o);
    return {23'b0, a, d, o};
  endfunction

  task automatic pulse(input bit c, input bit s,
                       input bit u, input bit d);
    @(negedge clk);
    tap_capture = c;
    tap_shift   = s;
    tap_update  = u;
    tap_tdi     = d;
    @(posedge clk);
    #1;
    tap_capture = 1'b0;
    tap_shift   = 1'b0;
    tap_update  = 1'b0;
    tap_tdi     = 1'b0;
  endtask

  // sel: 0 dtmcs, 1 dmi, 2 idcode
  task automatic dr_scan(input int sel, input int n,
                         input logic [63:0] din, input bit upd,
                         output logic [63:0] q);
    q = '0;
    tap_sel_dtmcs  = (sel == 0);
    tap_sel_dmi    = (sel == 1);
    tap_sel_idcode = (sel == 2);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      q[i] = tap_tdo;
      pulse(1'b0, 1'b1, 1'b0, din[i]);
    end
    if (upd) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tap_sel_dtmcs  = 1'b0;
    tap_sel_dmi    = 1'b0;
    tap_sel_idcode = 1'b0;
  endtask

  task automatic dm_resp(input logic [1:0] r, input logic [31:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!dmi.debug_resp_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("resp_ready_wait", dmi.debug_resp_ready, 1);
    dmi.debug_resp_valid     = 1'b1;
    dmi.debug_resp_bits_resp = r;
    dmi.debug_resp_bits_data = d;
    @(posedge clk);
    #1;
    dmi.debug_resp_valid     = 1'b0;
    dmi.debug_resp_bits_resp = 2'd0;
    dmi.debug_resp_bits_data = 32'd0;
  endtask

  task automatic req_hs();
    @(negedge clk);
    dmi.debug_req_ready = 1'b1;
    @(posedge clk);
    #1;
    dmi.debug_req_ready = 1'b0;
    check("req_hs_drop", dmi.debug_req_valid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    tap_sel_dtmcs = 1'b1;
    tap_sel_dmi = 1'b0;
    tap_sel_idcode = 1'b0;
    tap_capture = 1'b0;
    tap_shift = 1'b0;
    tap_update = 1'b0;
    tap_tdi = 1'b0;
    dmi.debug_req_ready = 1'b0;
    dmi.debug_resp_valid = 1'b0;
    dmi.debug_resp_bits_resp = 2'd0;
    dmi.debug_resp_bits_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", dmi.debug_req_valid, 0);
    check("rst_resp_ready", dmi.debug_resp_ready, 0);
    check("rst_addr", dmi.debug_req_bits_addr, 0);
    check("rst_op", dmi.debug_req_bits_op, 0);
    check("rst_data", dmi.debug_req_bits_data, 0);
    check("rst_tdo", tap_tdo, 0);
    @(negedge clk);
    reset = 1'b0;
    tap_sel_dtmcs = 1'b0;

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("nosel_tdo", tap_tdo, 0);

    dr_scan(0, 32, 64'd0, 1'b0, dout);
    check("dtmcs_cap", dout, 64'h1071);

    // write, DM ready immediately
    dmi.debug_req_ready = 1'b1;
    dr_scan(1, 41, mk(7'h10, 32'h8000_0001, 2'd2), 1'b1, dout);
    check("dmi_cap_rst", dout, 64'd0);
    check("wr_valid", dmi.debug_req_valid, 1);
    check("wr_addr", dmi.debug_req_bits_addr, 64'h10);
    check("wr_data", dmi.debug_req_bits_data, 64'h8000_0001);
    check("wr_op", dmi.debug_req_bits_op, 2);
    @(posedge clk);
    #1;
    check("wr_valid_1cyc", dmi.debug_req_valid, 0);
    dmi.debug_req_ready = 1'b0;
    dm_resp(2'd0, 32'd0);
    dr_scan(1, 41, 64'd0, 1'b0, dout);
    check("wr_cap", dout, mk(7'h10, 32'd0, 2'd0));

    // read with DM stalling ready
    dr_scan(1, 41, mk(7'h11, 32'd0, 2'd1), 1'b1, dout);
    check("rd_valid", dmi.debug_req_valid, 1);
    check("rd_addr", dmi.debug_req_bits_addr, 64'h11);
    check("rd_op", dmi.debug_req_bits_op, 1);
    repeat (5) @(posedge clk);
    #1;
    check("rd_stall_valid", dmi.debug_req_valid, 1);
    check("rd_stall_addr", dmi.debug_req_bits_addr, 64'h11);
    req_hs();
    dm_resp(2'd0, 32'h0000_0382);
    dr_scan(1, 41, 64'd0, 1'b0, dout);
    check("rd_cap", dout, mk(7'h11, 32'h382, 2'd0));

    // busy: second update while pending
    dr_scan(1, 41, mk(7'h12, 32'hAAAA_5555, 2'd2), 1'b1, dout);
    check("busy_first_valid", dmi.debug_req_valid, 1);
    req_hs();
    dr_scan(1, 41, mk(7'h13, 32'h1234, 2'd1), 1'b1, dout);
    check("busy_no_req", dmi.debug_req_valid, 0);
    dr_scan(1, 41, 64'd0, 1'b0, dout);
    check("busy_cap", dout, mk(7'h12, 32'h382, 2'd3));
    dm_resp(2'd0, 32'd0);
    dr_scan(1, 41, mk(7'h14, 32'd7, 2'd2), 1'b1, dout);
    check("sticky_cap", dout, mk(7'h12, 32'h382, 2'd3));
    check("sticky_no_req", dmi.debug_req_valid, 0);
    dr_scan(0, 32, 64'd0, 1'b0, dout);
    check("dtmcs_sticky3", dout, 64'h1C71);
    dr_scan(0, 32, 64'h1_0000, 1'b1, dout);
    dr_scan(0, 32, 64'd0, 1'b0, dout);
    check("dmireset_clear", dout, 64'h1071);
    dr_scan(1, 41, mk(7'h15, 32'h5, 2'd2), 1'b1, dout);
    check("post_reset_valid", dmi.debug_req_valid, 1);
    check("post_reset_addr", dmi.debug_req_bits_addr, 64'h15);
    req_hs();
    dm_resp(2'd0, 32'd0);

    // failed read sets sticky 2
    dr_scan(1, 41, mk(7'h16, 32'd0, 2'd1), 1'b1, dout);
    req_hs();
    dm_resp(2'd2, 32'hDEAD_BEEF);
    dr_scan(0, 32, 64'd0, 1'b0, dout);
    check("dtmcs_sticky2", dout, 64'h1871);
    dr_scan(1, 41, 64'd0, 1'b0, dout);
    check("err_cap", dout, mk(7'h16, 32'hDEAD_BEEF, 2'd2));
    dr_scan(0, 32, 64'h1_0000, 1'b1, dout);

    // dmihardreset with request outstanding
    dr_scan(1, 41, mk(7'h17, 32'd0, 2'd1), 1'b1, dout);
    check("hr_valid_before", dmi.debug_req_valid, 1);
    dr_scan(0, 32, 64'h2_0000, 1'b1, dout);
    check("hr_valid_drop", dmi.debug_req_valid, 0);
    check("hr_discard_ready", dmi.debug_resp_ready, 1);
    dm_resp(2'd0, 32'h1234_5678);
    check("hr_ready_clear", dmi.debug_resp_ready, 0);
    dr_scan(1, 41, 64'd0, 1'b0, dout);
    check("hr_cap", dout, mk(7'h17, 32'hDEAD_BEEF, 2'd0));

`ifdef DTM_IDCODE_EN
    dr_scan(2, 32, 64'd0, 1'b1, dout);
    check("idcode_cap", dout, 64'h2495_11C3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
